// File: rtl/pio_sm_core_if.sv
// pio_sm_core_if: system-side FIFO bus of a PIO state machine.
// Ports:
//   external_push_en / external_data_in : system writes into the TX FIFO
//   external_pop_en / external_data_out : system reads from the RX FIFO (head, 0 when empty)
//   tx_count, rx_count, tx_full, rx_empty : FIFO status seen by the system
// Modports: master = system side, slave = state machine core.
interface pio_sm_core_if #(
    parameter int FIFO_DEPTH = 4
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic          external_push_en;
    logic [31:0]   external_data_in;
    logic          external_pop_en;
    logic [31:0]   external_data_out;
    logic [CW-1:0] tx_count;
    logic [CW-1:0] rx_count;
    logic          tx_full;
    logic          rx_empty;

    modport master (
        output external_push_en, external_data_in, external_pop_en,
        input  external_data_out, tx_count, rx_count, tx_full, rx_empty
    );

    modport slave (
        input  external_push_en, external_data_in, external_pop_en,
        output external_data_out, tx_count, rx_count, tx_full, rx_empty
    );
endinterface

// File: rtl/pio_sm_core.sv
// pio_sm_core: single PIO state machine executing one 16-bit instruction per cycle.
// Ports:
//   clk, rst (sync, active-low)
//   instruction / pc      : instruction fetched at the current program counter
//   bus                   : TX/RX FIFO system interface (pio_sm_core_if.slave)
//   out_shiftdir          : 1 = OUT shifts right (LSB first), 0 = left (MSB first)
//   autopull, pull_thresh : OSR refill on OUT when the threshold is reached (0 means 32)
//   x, y, osr_data        : scratch registers and output shift register
//   out_shift_counter     : bits shifted out of the OSR, saturating at 32
//   osr_empty             : out_shift_counter has reached the pull threshold
module pio_sm_core #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [15:0]       instruction,
    output logic [4:0]        pc,
    pio_sm_core_if.slave      bus,
    input  logic              out_shiftdir,
    input  logic              autopull,
    input  logic [4:0]        pull_thresh,
    output logic [31:0]       x,
    output logic [31:0]       y,
    output logic [31:0]       osr_data,
    output logic [5:0]        out_shift_counter,
    output logic              osr_empty
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    localparam logic [2:0] OP_JMP  = 3'b000;
    localparam logic [2:0] OP_OUT  = 3'b011;
    localparam logic [2:0] OP_PP   = 3'b100;
    localparam logic [2:0] OP_MOV  = 3'b101;
    localparam logic [2:0] OP_SET  = 3'b111;

    logic [31:0]   isr;
    logic [31:0]   tx_mem [FIFO_DEPTH];
    logic [31:0]   rx_mem [FIFO_DEPTH];
    logic [AW-1:0] tx_head, tx_tail, rx_head, rx_tail;
    logic [CW-1:0] tx_cnt, rx_cnt;
    logic          tx_empty, tx_full, rx_empty, rx_full;
    logic          tx_push, tx_pop, rx_push, rx_pop;

    logic [2:0]    op, dst;
    logic [5:0]    n, thresh, cnt_n;
    logic [6:0]    cnt_sum;
    logic [31:0]   out_data, mov_src, mov_rev, mov_val;
    logic [31:0]   x_n, y_n, osr_n, isr_n;
    logic [4:0]    pc_n, pc_go;
    logic [7:0]    jmp_conds;
    logic          stall;
    logic          unused_delay;

    assign op           = instruction[15:13];
    assign dst          = instruction[7:5];
    assign unused_delay = ^instruction[12:8];

    assign tx_empty = tx_cnt == '0;
    assign tx_full  = tx_cnt == CW'(FIFO_DEPTH);
    assign rx_empty = rx_cnt == '0;
    assign rx_full  = rx_cnt == CW'(FIFO_DEPTH);
    assign tx_push  = bus.external_push_en && !tx_full;
    assign rx_pop   = bus.external_pop_en && !rx_empty;

    assign bus.tx_count          = tx_cnt;
    assign bus.rx_count          = rx_cnt;
    assign bus.tx_full           = tx_full;
    assign bus.rx_empty          = rx_empty;
    assign bus.external_data_out = rx_empty ? '0 : rx_mem[rx_head];

    assign thresh    = pull_thresh == '0 ? 6'd32 : {1'b0, pull_thresh};
    assign osr_empty = out_shift_counter >= thresh;

    // OUT bit count: a zero field means a full 32-bit shift
    assign n        = instruction[4:0] == '0 ? 6'd32 : {1'b0, instruction[4:0]};
    assign cnt_sum  = {1'b0, out_shift_counter} + {1'b0, n};
    // Shifting a 32-bit value by 32 yields zero, so n==32 needs no special case
    assign out_data = out_shiftdir ? osr_data & ~(32'hFFFF_FFFF << n)
                                   : osr_data >> (6'd32 - n);

    // Indexed by the JMP condition field
    assign jmp_conds = {!osr_empty, 1'b0, x != y, y != '0, y == '0, x != '0, x == '0, 1'b1};

    assign mov_src = instruction[2:0] == 3'd1 ? x :
                     instruction[2:0] == 3'd2 ? y :
                     instruction[2:0] == 3'd5 ? {32{tx_empty}} :
                     instruction[2:0] == 3'd6 ? isr :
                     instruction[2:0] == 3'd7 ? osr_data : '0;
    assign mov_rev = {<<{mov_src}};
    assign mov_val = instruction[4:3] == 2'd1 ? ~mov_src :
                     instruction[4:3] == 2'd2 ? mov_rev : mov_src;

    always_comb begin
        x_n     = x;
        y_n     = y;
        osr_n   = osr_data;
        isr_n   = isr;
        cnt_n   = out_shift_counter;
        pc_go   = pc + 5'd1;
        stall   = 1'b0;
        tx_pop  = 1'b0;
        rx_push = 1'b0;
        case (op)
            OP_JMP: begin
                if (dst == 3'b010) x_n = x - 32'd1;
                if (dst == 3'b100) y_n = y - 32'd1;
                if (jmp_conds[dst]) pc_go = instruction[4:0];
            end
            OP_OUT: begin
                if (autopull && osr_empty) begin
                    // Refill (if possible) and retry the OUT on the next cycle
                    stall = 1'b1;
                    if (!tx_empty) begin
                        tx_pop = 1'b1;
                        osr_n  = tx_mem[tx_head];
                        cnt_n  = '0;
                    end
                end else begin
                    osr_n = out_shiftdir ? osr_data >> n : osr_data << n;
                    cnt_n = cnt_sum > 7'd32 ? 6'd32 : cnt_sum[5:0];
                    if (dst == 3'b001) x_n = out_data;
                    if (dst == 3'b010) y_n = out_data;
                    if (dst == 3'b101) pc_go = out_data[4:0];
                end
            end
            OP_PP: begin
                if (instruction[7]) begin
                    if (!(instruction[6] && !osr_empty)) begin
                        if (!tx_empty) begin
                            tx_pop = 1'b1;
                            osr_n  = tx_mem[tx_head];
                            cnt_n  = '0;
                        end else if (instruction[5]) begin
                            stall = 1'b1;
                        end else begin
                            osr_n = x;
                            cnt_n = '0;
                        end
                    end
                end else begin
                    stall   = rx_full && instruction[5];
                    rx_push = !rx_full;
                    isr_n   = stall ? isr : '0;
                end
            end
            OP_MOV: begin
                if (dst == 3'b001) x_n = mov_val;
                if (dst == 3'b010) y_n = mov_val;
                if (dst == 3'b101) pc_go = mov_val[4:0];
                if (dst == 3'b110) isr_n = mov_val;
                if (dst == 3'b111) begin
                    osr_n = mov_val;
                    cnt_n = '0;
                end
            end
            OP_SET: begin
                if (dst == 3'b001) x_n = {27'd0, instruction[4:0]};
                if (dst == 3'b010) y_n = {27'd0, instruction[4:0]};
            end
            default: ;
        endcase
        pc_n = stall ? pc : pc_go;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            pc                <= '0;
            x                 <= '0;
            y                 <= '0;
            osr_data          <= '0;
            isr               <= '0;
            out_shift_counter <= 6'd32;
            tx_head           <= '0;
            tx_tail           <= '0;
            tx_cnt            <= '0;
            rx_head           <= '0;
            rx_tail           <= '0;
            rx_cnt            <= '0;
        end else begin
            pc                <= pc_n;
            x                 <= x_n;
            y                 <= y_n;
            osr_data          <= osr_n;
            isr               <= isr_n;
            out_shift_counter <= cnt_n;
            if (tx_push) tx_tail <= tx_tail + 1'b1;
            if (tx_pop) tx_head <= tx_head + 1'b1;
            tx_cnt <= tx_cnt + CW'(tx_push) - CW'(tx_pop);
            if (rx_push) rx_tail <= rx_tail + 1'b1;
            if (rx_pop) rx_head <= rx_head + 1'b1;
            rx_cnt <= rx_cnt + CW'(rx_push) - CW'(rx_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (rst && tx_push) tx_mem[tx_tail] <= bus.external_data_in;
        if (rst && rx_push) rx_mem[rx_tail] <= isr;
    end
endmodule

// File: tb/tb_pio_sm_core.sv
// tb_pio_sm_core: directed self-checking bench for pio_sm_core with FIFO scoreboards.
module tb_pio_sm_core;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] instruction;
    logic [4:0]  pc;
    logic        out_shiftdir = 1'b1;
    logic        autopull = 1'b0;
    logic [4:0]  pull_thresh = 5'd0;
    logic [31:0] x, y, osr_data;
    logic [5:0]  out_shift_counter;
    logic        osr_empty;
    logic [15:0] prog [32];
    logic [31:0] tx_model [$];
    logic [31:0] rx_model [$];
    int          total = 0;
    int          bad = 0;

    pio_sm_core_if bus_if ();

    pio_sm_core dut (
        .clk               (clk),
        .rst               (rst),
        .instruction       (instruction),
        .pc                (pc),
        .bus               (bus_if),
        .out_shiftdir      (out_shiftdir),
        .autopull          (autopull),
        .pull_thresh       (pull_thresh),
        .x                 (x),
        .y                 (y),
        .osr_data          (osr_data),
        .out_shift_counter (out_shift_counter),
        .osr_empty         (osr_empty)
    );

    always #5 clk = ~clk;

    assign instruction = prog[pc];

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        assert (act === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, act, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b0;
        step(2);
        rst = 1'b1;
    endtask

    task automatic fill_prog(input logic [15:0] v);
        for (int i = 0; i < 32; i++) prog[i] = v;
    endtask

    initial begin
        bus_if.external_push_en = 1'b0;
        bus_if.external_data_in = '0;
        bus_if.external_pop_en  = 1'b0;
        fill_prog(16'h2000);

        // Reset state, then free-running NOPs wrap pc
        step(2);
        chk("rst_pc", 32'(pc), 32'd0);
        chk("rst_x", x, 32'd0);
        chk("rst_y", y, 32'd0);
        chk("rst_cnt", 32'(out_shift_counter), 32'd32);
        chk("rst_osr_empty", 32'(osr_empty), 32'd1);
        chk("rst_tx_count", 32'(bus_if.tx_count), 32'd0);
        chk("rst_rx_count", 32'(bus_if.rx_count), 32'd0);
        chk("rst_rx_empty", 32'(bus_if.rx_empty), 32'd1);
        rst = 1'b1;
        for (int i = 0; i <= 32; i++) begin
            chk("nop_pc", 32'(pc), 32'(i % 32));
            step(1);
        end

        // SET X,5 then JMP X-- loop: five taken jumps, sixth falls through
        fill_prog(16'h0002);
        prog[0]  = 16'hE025;
        prog[1]  = 16'h004A;
        prog[10] = 16'h0001;
        do_reset();
        step(1);
        chk("set_x", x, 32'd5);
        for (int k = 1; k <= 5; k++) begin
            step(1);
            chk("jmp_x", x, 32'(5 - k));
            chk("jmp_pc", 32'(pc), 32'd10);
            step(1);
        end
        step(1);
        chk("jmp_fall_x", x, 32'hFFFF_FFFF);
        chk("jmp_fall_pc", 32'(pc), 32'd2);

        // Blocking PULL on empty TX, late push, then OUT X,8 right
        fill_prog(16'h0002);
        prog[0] = 16'h80A0;
        prog[1] = 16'h6028;
        do_reset();
        step(2);
        chk("pull_wait_pc", 32'(pc), 32'd0);
        bus_if.external_push_en = 1'b1;
        bus_if.external_data_in = 32'h1234_5678;
        step(1);
        bus_if.external_push_en = 1'b0;
        chk("pull_wait_pc2", 32'(pc), 32'd0);
        chk("pull_tx_count", 32'(bus_if.tx_count), 32'd1);
        step(1);
        chk("pull_pc", 32'(pc), 32'd1);
        chk("pull_osr", osr_data, 32'h1234_5678);
        chk("pull_cnt", 32'(out_shift_counter), 32'd0);
        chk("pull_tx_empty", 32'(bus_if.tx_count), 32'd0);
        step(1);
        chk("out_r_x", x, 32'h0000_0078);
        chk("out_r_osr", osr_data, 32'h0012_3456);
        chk("out_r_cnt", 32'(out_shift_counter), 32'd8);

        // Same with left shift
        out_shiftdir = 1'b0;
        do_reset();
        bus_if.external_push_en = 1'b1;
        step(1);
        bus_if.external_push_en = 1'b0;
        step(2);
        chk("out_l_x", x, 32'h0000_0012);
        chk("out_l_osr", osr_data, 32'h3456_7800);
        chk("out_l_cnt", 32'(out_shift_counter), 32'd8);

        // Autopull at threshold 8: one refill stall, then OUT Y,8
        out_shiftdir = 1'b1;
        autopull     = 1'b1;
        pull_thresh  = 5'd8;
        fill_prog(16'h0002);
        prog[0] = 16'h2000;
        prog[1] = 16'h6048;
        do_reset();
        bus_if.external_push_en = 1'b1;
        bus_if.external_data_in = 32'hA5A5_A5A5;
        step(1);
        bus_if.external_push_en = 1'b0;
        chk("ap_pc0", 32'(pc), 32'd1);
        chk("ap_tx_count", 32'(bus_if.tx_count), 32'd1);
        step(1);
        chk("ap_stall_pc", 32'(pc), 32'd1);
        chk("ap_refill_osr", osr_data, 32'hA5A5_A5A5);
        chk("ap_refill_cnt", 32'(out_shift_counter), 32'd0);
        chk("ap_refill_y", y, 32'd0);
        chk("ap_not_empty", 32'(osr_empty), 32'd0);
        step(1);
        chk("ap_y", y, 32'h0000_00A5);
        chk("ap_cnt", 32'(out_shift_counter), 32'd8);
        chk("ap_empty_at_thresh", 32'(osr_empty), 32'd1);
        chk("ap_pc", 32'(pc), 32'd2);
        autopull    = 1'b0;
        pull_thresh = 5'd0;

        // TX overfill drops the fifth word; drain with PULL + OUT X,32
        fill_prog(16'h0000);
        do_reset();
        for (int i = 0; i < 5; i++) begin
            bus_if.external_push_en = 1'b1;
            bus_if.external_data_in = 32'hC0DE_0000 + 32'(i);
            if (i < 4) tx_model.push_back(32'hC0DE_0000 + 32'(i));
            step(1);
        end
        bus_if.external_push_en = 1'b0;
        chk("tx_full_count", 32'(bus_if.tx_count), 32'd4);
        chk("tx_full_flag", 32'(bus_if.tx_full), 32'd1);
        prog[0] = 16'h80A0;
        prog[1] = 16'h6020;
        prog[2] = 16'h0000;
        for (int i = 0; i < 4; i++) begin
            step(3);
            chk("tx_drain_x", x, tx_model.pop_front());
        end
        chk("tx_drained", 32'(bus_if.tx_count), 32'd0);

        // MOV ISR,~X then PUSH block x5 against a full RX FIFO
        fill_prog(16'h0006);
        prog[0] = 16'hA0C9;
        for (int i = 1; i <= 5; i++) prog[i] = 16'h8020;
        do_reset();
        rx_model.push_back(32'hFFFF_FFFF);
        for (int i = 0; i < 4; i++) rx_model.push_back(32'd0);
        step(6);
        chk("rx_full_count", 32'(bus_if.rx_count), 32'd4);
        chk("rx_stall_pc", 32'(pc), 32'd5);
        chk("rx_head", bus_if.external_data_out, rx_model.pop_front());
        bus_if.external_pop_en = 1'b1;
        step(1);
        bus_if.external_pop_en = 1'b0;
        chk("rx_pop_pc", 32'(pc), 32'd5);
        chk("rx_pop_count", 32'(bus_if.rx_count), 32'd3);
        step(1);
        chk("rx_resume_pc", 32'(pc), 32'd6);
        chk("rx_resume_count", 32'(bus_if.rx_count), 32'd4);
        for (int i = 0; i < 4; i++) begin
            chk("rx_drain", bus_if.external_data_out, rx_model.pop_front());
            bus_if.external_pop_en = 1'b1;
            step(1);
        end
        chk("rx_empty_flag", 32'(bus_if.rx_empty), 32'd1);
        chk("rx_empty_data", bus_if.external_data_out, 32'd0);
        step(1);
        bus_if.external_pop_en = 1'b0;
        chk("rx_empty_pop", 32'(bus_if.rx_count), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
